// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, legality check and FSM states for the shared ALU controller
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic w_legal;
      w_legal = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: w_legal = 1'b1;
         default:                               w_legal = 1'b0;
      endcase
      return w_legal;
   endfunction

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; a tie goes to the port not granted last
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_port
);

   always_comb begin
      grant_valid = |req_valid;
      grant_port  = 1'b0;
      if (req_valid == 2'b11)
         grant_port = ~last_grant;
      else
         grant_port = req_valid[1];
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - time-shares one registered ALU between two requesters
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_err,
   output logic [3:0]       alu_sel,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_result
);

   state_t           r_state;
   logic             r_owner;
   logic             r_last_grant;
   logic [3:0]       r_alu_sel;
   logic [WIDTH-1:0] r_alu_in1;
   logic [WIDTH-1:0] r_alu_in2;
   logic [1:0]       r_resp_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_err;

   logic             w_grant_valid;
   logic             w_grant_port;
   logic             w_accept;
   logic [3:0]       w_op;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   rr_arb2 u_arb (
      .req_valid   (req_valid),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant_port  (w_grant_port)
   );

   assign w_accept  = (r_state == ST_IDLE) && w_grant_valid;
   assign req_ready = w_accept ? port_onehot(w_grant_port) : 2'b00;

   assign w_op = w_grant_port ? req1_op : req0_op;
   assign w_a  = w_grant_port ? req1_a  : req0_a;
   assign w_b  = w_grant_port ? req1_b  : req0_b;

   // ALU inputs only move on a legal accept, so rejected ops never disturb the ALU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_alu_sel    <= '0;
         r_alu_in1    <= '0;
         r_alu_in2    <= '0;
         r_resp_valid <= 2'b00;
         r_result     <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner <= w_grant_port;
                  if (is_legal_op(w_op)) begin
                     r_alu_sel <= w_op;
                     r_alu_in1 <= w_a;
                     r_alu_in2 <= w_b;
                     r_state   <= ST_ISSUE;
                  end else begin
                     r_result     <= '0;
                     r_err        <= 1'b1;
                     r_resp_valid <= port_onehot(w_grant_port);
                     r_state      <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_result     <= alu_result;
               r_err        <= 1'b0;
               r_resp_valid <= port_onehot(r_owner);
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready[r_owner]) begin
                  r_resp_valid <= 2'b00;
                  r_last_grant <= r_owner;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign resp_valid  = r_resp_valid;
   assign resp_result = r_result;
   assign resp_err    = r_err;
   assign alu_sel     = r_alu_sel;
   assign alu_in1     = r_alu_in1;
   assign alu_in2     = r_alu_in2;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl with a registered ALU model
module tb_alu_share_ctrl;

   localparam logic [3:0] T_AND = 4'b0000;
   localparam logic [3:0] T_OR  = 4'b0001;
   localparam logic [3:0] T_ADD = 4'b0010;
   localparam logic [3:0] T_SUB = 4'b0110;
   localparam logic [3:0] T_SLT = 4'b0111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready = 2'b11;
   logic [31:0] resp_result;
   logic        resp_err;
   logic [3:0]  alu_sel;
   logic [31:0] alu_in1, alu_in2;
   logic [31:0] alu_q = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic        port;
      logic [31:0] result;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   alu_share_ctrl #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req0_op     (req0_op),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_op     (req1_op),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_err    (resp_err),
      .alu_sel     (alu_sel),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_result  (alu_q)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         T_AND:   return a & b;
         T_OR:    return a | b;
         T_ADD:   return a + b;
         T_SUB:   return a - b;
         T_SLT:   return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic legal(input logic [3:0] op);
      return (op == T_AND) || (op == T_OR) || (op == T_ADD) || (op == T_SUB) || (op == T_SLT);
   endfunction

   always @(posedge clk) begin
      alu_q <= alu_ref(alu_sel, alu_in1, alu_in2);
      cyc   <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.port   = port;
      e.err    = !legal(op);
      e.result = legal(op) ? alu_ref(op, a, b) : 32'd0;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && |(resp_valid & resp_ready)) begin
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("resp_port",   {31'b0, resp_valid[1]}, {31'b0, mon_e.port});
            check_eq("resp_onehot", $countones(resp_valid), 32'd1);
            check_eq("resp_result", resp_result, mon_e.result);
            check_eq("resp_err",    {31'b0, resp_err}, {31'b0, mon_e.err});
         end
      end
   end

   task automatic set_port(input logic port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (port) begin
         req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_op = op; req0_a = a; req0_b = b;
      end
      req_valid[port] = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic do_req(input logic port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int acc_cyc);
      bit ok;
      ok = 0;
      acc_cyc = 0;
      if (push) push_exp(port, op, a, b);
      set_port(port, op, a, b);
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         ok = req_ready[port];
         @(posedge clk);
         #1;
         acc_cyc = cyc;
      end
      if (!ok) check_eq("req_timeout", 32'd0, 32'd1);
      req_valid[port] = 1'b0;
   endtask

   task automatic run_tie(input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic first);
      logic [1:0] pend, acc;
      if (first) begin
         push_exp(1'b1, op1, a1, b1); push_exp(1'b0, op0, a0, b0);
      end else begin
         push_exp(1'b0, op0, a0, b0); push_exp(1'b1, op1, a1, b1);
      end
      set_port(1'b0, op0, a0, b0);
      set_port(1'b1, op1, a1, b1);
      pend = 2'b11;
      for (int i = 0; i < 60 && pend != 2'b00; i++) begin
         #1;
         acc = req_ready & pend;
         if (acc != 2'b00) check_eq("tie_grant_onehot", $countones(req_ready), 32'd1);
         @(posedge clk);
         #1;
         pend      = pend & ~acc;
         req_valid = req_valid & ~acc;
      end
      check_eq("tie_all_accepted", {30'b0, pend}, 32'd0);
      req_valid = 2'b00;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && !(sb.size() == 0 && resp_valid == 2'b00); i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("drain", sb.size(), 32'd0);
   endtask

   initial begin
      int c0, c1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_req_ready",  {30'b0, req_ready}, 32'd0);
      check_eq("rst_resp_valid", {30'b0, resp_valid}, 32'd0);
      check_eq("rst_result",     resp_result, 32'd0);
      check_eq("rst_err",        {31'b0, resp_err}, 32'd0);
      check_eq("rst_alu_sel",    {28'b0, alu_sel}, 32'd0);
      check_eq("rst_alu_in1",    alu_in1, 32'd0);
      check_eq("rst_alu_in2",    alu_in2, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Both valid straight out of reset: port 0 wins, then port 1.
      run_tie(T_SUB, 32'd10, 32'd3, T_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
      drain();
      run_tie(T_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, T_ADD, 32'd40, 32'd2, 1'b0);
      drain();

      // Latency: accept E0, response visible after E2.
      do_req(1'b0, T_ADD, 32'd5, 32'd7, 1'b1, c0);
      check_eq("lat_e0_valid", {30'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      check_eq("lat_e1_valid", {30'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      check_eq("lat_e2_valid", {30'b0, resp_valid}, 32'd1);
      check_eq("lat_e2_result", resp_result, 32'd12);
      drain();

      // Throughput with resp_ready held high: one op per 4 cycles.
      do_req(1'b0, T_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, c0);
      do_req(1'b0, T_SUB, 32'd0, 32'd1, 1'b1, c1);
      check_eq("throughput", c1 - c0, 32'd4);
      drain();

      do_req(1'b1, T_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, c0);
      drain();
      do_req(1'b1, T_SLT, 32'd1, 32'hFFFF_FFFF, 1'b1, c0);
      drain();

      // Illegal opcode: immediate error response, ALU inputs keep last legal op.
      do_req(1'b0, 4'b0011, 32'd55, 32'd66, 1'b1, c0);
      check_eq("ill_valid",   {30'b0, resp_valid}, 32'd1);
      check_eq("ill_err",     {31'b0, resp_err}, 32'd1);
      check_eq("ill_result",  resp_result, 32'd0);
      check_eq("ill_alu_sel", {28'b0, alu_sel}, {28'b0, T_SLT});
      check_eq("ill_alu_in1", alu_in1, 32'd1);
      check_eq("ill_alu_in2", alu_in2, 32'hFFFF_FFFF);
      drain();

      // Backpressure on port 0 while port 1 waits; non-owner ready ignored.
      resp_ready = 2'b00;
      do_req(1'b0, T_ADD, 32'd100, 32'd23, 1'b1, c0);
      push_exp(1'b1, T_OR, 32'h30, 32'h03);
      set_port(1'b1, T_OR, 32'h30, 32'h03);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_eq("bp_valid",  {30'b0, resp_valid}, 32'd1);
         check_eq("bp_result", resp_result, 32'd123);
         check_eq("bp_ready1", {31'b0, req_ready[1]}, 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 2'b01;
      @(posedge clk); #1;
      check_eq("bp_release_grant", {30'b0, req_ready}, 32'd2);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      resp_ready = 2'b11;
      drain();

      // Reset while the ALU result is being captured.
      do_req(1'b0, T_ADD, 32'd9, 32'd9, 1'b0, c0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_req_ready",  {30'b0, req_ready}, 32'd0);
      check_eq("mid_rst_resp_valid", {30'b0, resp_valid}, 32'd0);
      check_eq("mid_rst_result",     resp_result, 32'd0);
      check_eq("mid_rst_err",        {31'b0, resp_err}, 32'd0);
      check_eq("mid_rst_alu_sel",    {28'b0, alu_sel}, 32'd0);
      check_eq("mid_rst_alu_in1",    alu_in1, 32'd0);
      check_eq("mid_rst_alu_in2",    alu_in2, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_eq("post_rst_no_resp", {30'b0, resp_valid}, 32'd0);
      end
      do_req(1'b0, T_ADD, 32'd1, 32'd1, 1'b1, c0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that time-shares the single registered ALU between two requesters (port 0: integer execute stage, port 1: address/branch compare unit). It arbitrates round-robin, sequences one operation at a time through the ALU's one-cycle registered result path, rejects unsupported opcodes without using the ALU, and returns each result on a per-port valid/ready response channel. It sits between the requesters and the ALU and is the only driver of the ALU's operand and selection inputs.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (must match ALU)

Ports:
- `clk`  in  1  rising-edge clock, shared with ALU
- `rst`  in  1  asynchronous, active-high reset
- `req_valid[1:0]`  in  2  request present, per port
- `req_ready[1:0]`  out  2  request accepted this cycle, per port
- `req0_op`, `req1_op`  in  4  ALU selection code
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `resp_valid[1:0]`  out  2  result available, per port
- `resp_ready[1:0]`  in  2  requester takes result
- `resp_result`  out  WIDTH  result (shared; qualified by `resp_valid`)
- `resp_err`  out  1  unsupported opcode flag (qualified by `resp_valid`)
- `alu_sel`  out  4  to ALU `selectionLines`
- `alu_in1`, `alu_in2`  out  WIDTH  to ALU operands
- `alu_result`  in  WIDTH  from ALU (registered inside ALU)

## Operation
- Legal ops: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (unsigned compare, result 0/1). Any other code is illegal.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any `req_valid`, grant one port; `req_ready` high only for the granted port (combinational, only in IDLE). On that edge latch op, a, b, owner; legal op -> ISSUE, illegal -> RESP with err=1, result 0.
- ISSUE: `alu_sel/alu_in1/alu_in2` driven from latched registers; ALU samples at the end of this cycle -> CAPTURE.
- CAPTURE: `alu_result` now valid; register it into the response register, err=0 -> RESP.
- RESP: `resp_valid[owner]`=1, other bit 0; result/err held stable. On `resp_ready[owner]` -> IDLE, `last_grant` <= owner. `resp_ready` of the non-owner is ignored.
- Arbitration: single requester wins; both valid -> port != `last_grant`. `last_grant` resets to 1 (port 0 wins first tie).
- ALU drive outside ISSUE: latched values held (no toggling); ALU output in those cycles is don't-care.
- Requests must hold op/operands stable while valid and not ready; controller does not check this.

## Timing
- Reset (async assert, sync deassert at system level): state IDLE, `req_ready`=0, `resp_valid`=0, `resp_result`=0, `resp_err`=0, `alu_sel`=0, `alu_in1/2`=0, `last_grant`=1.
- Legal op: accept edge E0; `resp_valid` high after edge E2 (2 cycles post-accept). With `resp_ready` already high, next accept no earlier than E4; throughput one op per 4 cycles.
- Illegal op: `resp_valid` high after E0 (next cycle); ALU untouched.
- No new request accepted while ISSUE/CAPTURE/RESP; `req_ready`=0 in those states.
- Reset mid-operation: in-flight transaction dropped, no response; requester reissues.

## Structure
- `alu_pkg`: opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), `is_legal_op` function, FSM state enum.
- Sub-module `rr_arb2`: 2-way round-robin grant from `req_valid` and `last_grant`; all else in the top.

## Test plan
- Port 0 ADD a=5, b=7 -> `req_ready[0]` at E0, `resp_valid[0]` after E2, result 12, err 0.
- Both valid after reset (port0 SUB 10-3, port1 OR F0|0F) -> port 0 first (7), then port 1 (0xFF); third tie goes to port 0.
- Port 1 SLT a=0xFFFF_FFFF, b=1 -> result 0; swapped operands -> 1.
- Port 0 op 0011 -> `resp_valid[0]` one cycle after accept, err 1, result 0; `alu_sel` unchanged.
- Hold `resp_ready[0]`=0 for 5 cycles with port 1 valid -> result stable, `req_ready[1]`=0 throughout; port 1 granted on cycle after release.
- Assert `rst` during CAPTURE -> next cycle all outputs 0, no response issued; fresh ADD 1+1 returns 2.
